// File: rtl/taxi_ram_rd_pkg.sv
// Shared types and constants for the taxi_ram_rd streaming read engine.
package taxi_ram_rd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int BUF_DEPTH = 2;
   localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/taxi_ram_rd_buf.sv
// Two-entry {data,last} FIFO that absorbs the RAM read latency.
// Entry 0 is always the head, so the output is taken straight from registers.
module taxi_ram_rd_buf
   import taxi_ram_rd_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              push_last,
   input  logic              pop,
   input  logic              flush,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic [OCC_W-1:0]  occ
);

   logic [DATA_W-1:0] data0_q, data0_d;
   logic [DATA_W-1:0] data1_q, data1_d;
   logic              last0_q, last0_d;
   logic              last1_q, last1_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic [OCC_W-1:0]  keep;

   always_comb begin
      data0_d = data0_q;
      data1_d = data1_q;
      last0_d = last0_q;
      last1_d = last1_q;
      keep    = occ_q - OCC_W'(pop);
      occ_d   = keep + OCC_W'(push);

      if (pop) begin
         data0_d = data1_q;
         last0_d = last1_q;
      end

      // New beat lands in the first slot left free after this cycle's pop.
      if (push) begin
         if (keep == '0) begin
            data0_d = push_data;
            last0_d = push_last;
         end else begin
            data1_d = push_data;
            last1_d = push_last;
         end
      end

      if (flush) begin
         occ_d   = '0;
         last0_d = 1'b0;
         last1_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data0_q <= '0;
         data1_q <= '0;
         last0_q <= 1'b0;
         last1_q <= 1'b0;
         occ_q   <= '0;
      end else begin
         data0_q <= data0_d;
         data1_q <= data1_d;
         last0_q <= last0_d;
         last1_q <= last1_d;
         occ_q   <= occ_d;
      end
   end

   assign out_valid = (occ_q != '0);
   assign out_data  = data0_q;
   assign out_last  = last0_q && out_valid;
   assign occ       = occ_q;

endmodule

// File: rtl/taxi_ram_rd_stream.sv
// Streaming read engine: turns an (addr, len) command into sequential RAM reads
// returned as a valid/ready stream. Optional abort input: TAXI_RAM_RD_ABORT_EN.
module taxi_ram_rd_stream
   import taxi_ram_rd_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef TAXI_RAM_RD_ABORT_EN
   input  logic              cmd_abort,
`endif
   input  logic [ADDR_W-1:0] s_cmd_addr,
   input  logic [LEN_W-1:0]  s_cmd_len,
   input  logic              s_cmd_valid,
   output logic              s_cmd_ready,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_rd_addr,
   input  logic [DATA_W-1:0] ram_rd_data,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              busy
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic              rd_en_q, rd_en_d;
   logic              rd_last_q, rd_last_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              busy_q, busy_d;

   logic              issue;
   logic              pop;
   logic              abort_hit;
   logic [2:0]        level;
   logic [OCC_W-1:0]  occ;
   logic              buf_valid;
   logic              buf_last;
   logic [DATA_W-1:0] buf_data;

   assign pop = buf_valid && m_ready;

`ifdef TAXI_RAM_RD_ABORT_EN
   assign abort_hit = cmd_abort && (state_q != ST_IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   // Beats the buffer must still hold after this cycle; issue only if one slot stays free.
   assign level = 3'(occ) + 3'(rd_en_q) - 3'(pop);
   assign issue = (state_q == ST_READ) && (level < 3'(BUF_DEPTH)) && !abort_hit;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      rd_en_d   = issue;
      rd_last_d = issue && (cnt_q == '0);

      case (state_q)
         ST_IDLE: begin
            if (s_cmd_valid && cmd_ready_q) begin
               state_d = ST_READ;
               addr_d  = s_cmd_addr;
               cnt_d   = s_cmd_len;
            end
         end
         ST_READ: begin
            if (issue) begin
               addr_d = addr_q + ADDR_W'(1);
               cnt_d  = cnt_q - LEN_W'(1);
               if (cnt_q == '0) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (pop && buf_last) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (abort_hit) begin
         state_d = ST_IDLE;
      end

      cmd_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         cnt_q       <= '0;
         rd_en_q     <= 1'b0;
         rd_last_q   <= 1'b0;
         cmd_ready_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         rd_en_q     <= rd_en_d;
         rd_last_q   <= rd_last_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
      end
   end

   // The beat returning this cycle is dropped on abort so nothing stale follows it.
   taxi_ram_rd_buf #(
      .DATA_W(DATA_W)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (rd_en_q && !abort_hit),
      .push_data (ram_rd_data),
      .push_last (rd_last_q),
      .pop       (pop),
      .flush     (abort_hit),
      .out_valid (buf_valid),
      .out_data  (buf_data),
      .out_last  (buf_last),
      .occ       (occ)
   );

   assign s_cmd_ready = cmd_ready_q;
   assign ram_rd_en   = issue;
   assign ram_rd_addr = addr_q;
   assign m_data      = buf_data;
   assign m_last      = buf_last;
   assign m_valid     = buf_valid;
   assign busy        = busy_q;

endmodule

// File: tb/tb_taxi_ram_rd_stream.sv
// Scoreboard bench for taxi_ram_rd_stream: commands push expected reads/beats,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_taxi_ram_rd_stream;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;
   localparam int LEN_W  = 16;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
   } beat_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [ADDR_W-1:0] s_cmd_addr = '0;
   logic [LEN_W-1:0]  s_cmd_len = '0;
   logic              s_cmd_valid = 1'b0;
   logic              s_cmd_ready;
   logic              ram_rd_en;
   logic [ADDR_W-1:0] ram_rd_addr;
   logic [DATA_W-1:0] ram_rd_data = '0;
   logic [DATA_W-1:0] m_data;
   logic              m_last;
   logic              m_valid;
   logic              m_ready = 1'b0;
   logic              busy;
`ifdef TAXI_RAM_RD_ABORT_EN
   logic              cmd_abort = 1'b0;
`endif

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   int          pops = 0;
   int          first_pop_cyc = 0;
   int          last_pop_cyc = 0;
   bit          chk_en = 1'b0;
   bit          exp_busy = 1'b0;
   bit          first_rd_pending = 1'b0;
   bit          first_beat_pending = 1'b0;
   bit          prev_stall = 1'b0;
   logic [DATA_W-1:0] prev_data = '0;
   logic              prev_last = 1'b0;
   bit          ready_rand = 1'b0;
   logic        ready_val = 1'b1;

   beat_t             exp_q[$];
   logic [ADDR_W-1:0] addr_exp[$];
   beat_t             mon_b;
   logic [ADDR_W-1:0] mon_a;

   always #5 clk = ~clk;

   taxi_ram_rd_stream #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .LEN_W (LEN_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
`ifdef TAXI_RAM_RD_ABORT_EN
      .cmd_abort   (cmd_abort),
`endif
      .s_cmd_addr  (s_cmd_addr),
      .s_cmd_len   (s_cmd_len),
      .s_cmd_valid (s_cmd_valid),
      .s_cmd_ready (s_cmd_ready),
      .ram_rd_en   (ram_rd_en),
      .ram_rd_addr (ram_rd_addr),
      .ram_rd_data (ram_rd_data),
      .m_data      (m_data),
      .m_last      (m_last),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .busy        (busy)
   );

   function automatic logic [DATA_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] p;
      p = a * 16'h9E37;
      return p ^ 16'h5A5A;
   endfunction

   // RAM contents are a fixed function of the address; 1-cycle registered read.
   always @(posedge clk) begin
      if (ram_rd_en) ram_rd_data <= mem_val(ram_rd_addr);
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         m_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
      end
   end

   // Monitor
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (chk_en) begin
               check("busy", busy, exp_busy);
               check("cmd_ready", s_cmd_ready, !exp_busy);
            end
            if (ram_rd_en) begin
               if (addr_exp.size() == 0) begin
                  check("spurious_rd", 1, 0);
               end else begin
                  mon_a = addr_exp.pop_front();
                  check("rd_addr", ram_rd_addr, mon_a);
                  if (first_rd_pending) begin
                     check("rd_latency", cyc - acc_cyc, 0);
                     first_rd_pending = 1'b0;
                  end
               end
            end
            if (prev_stall) begin
               check("stall_valid", m_valid, 1);
               check("stall_data", m_data, prev_data);
               check("stall_last", m_last, prev_last);
            end
            if (m_valid && first_beat_pending) begin
               check("beat_latency", cyc - acc_cyc, 2);
               first_beat_pending = 1'b0;
            end
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  check("spurious_beat", 1, 0);
               end else begin
                  mon_b = exp_q.pop_front();
                  check("beat_data", m_data, mon_b.data);
                  check("beat_last", m_last, mon_b.last);
                  pops++;
                  if (pops == 1) first_pop_cyc = cyc;
                  last_pop_cyc = cyc;
                  if (mon_b.last) exp_busy = 1'b0;
               end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
         end
      end
   end

   task automatic send_cmd(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
      bit acc;
      logic [ADDR_W-1:0] a;
      acc = 1'b0;
      @(posedge clk);
      #1;
      s_cmd_addr  = addr;
      s_cmd_len   = len;
      s_cmd_valid = 1'b1;
      for (int i = 0; i < 1000 && !acc; i++) begin
         @(negedge clk);
         acc = s_cmd_ready;
         @(posedge clk);
      end
      #1;
      s_cmd_valid = 1'b0;
      if (!acc) begin
         check("cmd_accept_timeout", 0, 1);
      end else begin
         acc_cyc = cyc;
         exp_busy = 1'b1;
         first_rd_pending = 1'b1;
         first_beat_pending = 1'b1;
         pops = 0;
         for (int i = 0; i <= int'(len); i++) begin
            a = addr + ADDR_W'(i);
            addr_exp.push_back(a);
            exp_q.push_back('{data: mem_val(a), last: (i == int'(len))});
         end
      end
   endtask

   task automatic wait_done(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 5000 && !done; i++) begin
         @(posedge clk);
         done = (exp_q.size() == 0) && !exp_busy;
      end
      if (!done) check({name, "_timeout"}, 0, 1);
      repeat (2) @(posedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_m_valid"}, m_valid, 0);
      check({tag, "_m_last"}, m_last, 0);
      check({tag, "_m_data"}, m_data, 0);
      check({tag, "_rd_en"}, ram_rd_en, 0);
      check({tag, "_rd_addr"}, ram_rd_addr, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_cmd_ready"}, s_cmd_ready, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [ADDR_W-1:0] ra;
      logic [LEN_W-1:0]  rl;

      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      #2 rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("ready_after_reset", s_cmd_ready, 1);
      chk_en = 1'b1;

      // Single beat
      ready_rand = 1'b0;
      ready_val  = 1'b1;
      send_cmd(16'h0010, 16'd0);
      wait_done("single");

      // Eight beats back to back
      send_cmd(16'h0100, 16'd7);
      wait_done("burst8");
      check("no_bubbles", last_pop_cyc - first_pop_cyc, 7);

      // Same burst under random backpressure
      ready_rand = 1'b1;
      send_cmd(16'h0100, 16'd7);
      wait_done("burst8_stall");

      // Address wrap
      ready_rand = 1'b0;
      send_cmd(16'hFFFE, 16'd3);
      wait_done("wrap");

      // Random bursts with random backpressure
      ready_rand = 1'b1;
      for (int n = 0; n < 6; n++) begin
         ra = ADDR_W'($urandom);
         if (n == 0) ra = 16'hFFF8;
         rl = LEN_W'($urandom_range(0, 20));
         send_cmd(ra, rl);
         wait_done("random");
      end

      // Reset during beat 3 of 8
      ready_rand = 1'b0;
      ready_val  = 1'b1;
      send_cmd(16'h0400, 16'd7);
      for (int i = 0; i < 200 && pops < 3; i++) @(posedge clk);
      check("pops_before_reset", pops >= 3, 1);
      #1;
      chk_en = 1'b0;
      rst_n = 1'b0;
      exp_q.delete();
      addr_exp.delete();
      exp_busy = 1'b0;
      first_rd_pending = 1'b0;
      first_beat_pending = 1'b0;
      @(negedge clk);
      check_reset_outputs("midreset");
      #2 rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("ready_after_midreset", s_cmd_ready, 1);
      chk_en = 1'b1;
      send_cmd(16'h0500, 16'd7);
      wait_done("after_reset");

`ifdef TAXI_RAM_RD_ABORT_EN
      // Abort while stalled with the buffer full
      ready_val = 1'b0;
      send_cmd(16'h0200, 16'd15);
      repeat (4) @(posedge clk);
      #1;
      cmd_abort = 1'b1;
      @(posedge clk);
      #1;
      cmd_abort = 1'b0;
      exp_q.delete();
      addr_exp.delete();
      exp_busy = 1'b0;
      prev_stall = 1'b0;
      first_rd_pending = 1'b0;
      first_beat_pending = 1'b0;
      @(negedge clk);
      check("abort_m_valid", m_valid, 0);
      check("abort_m_last", m_last, 0);
      check("abort_cmd_ready", s_cmd_ready, 1);
      ready_val = 1'b1;
      send_cmd(16'h0300, 16'd15);
      wait_done("after_abort");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
